frame_config_sequencer: RTL

Frame-synchronous configuration sequencer for the feature-detection filter chain. It debounces the raw mode switches (octave/selector bits), holds the applied configuration constant for a whole frame, and applies any change only at a frame-start request. Applying a change means draining the filter pipeline, pulsing a flush, and only then forwarding the start request. It sits between the ImageBufferWriter's start handshake and the StaticImage source, and drives the flush and selector inputs of the Check4/Check4_4x chain.

---
 rtl/frame_config_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer
// Debounces the raw mode switches and applies a new filter-chain configuration
// only at a frame-start request: the pipeline is drained, flushed for a fixed
// number of cycles, and only then is the start request passed to the image
// source. With no pending change the start request passes straight through.
module frame_config_sequencer #(
    parameter int                 CFG_W         = 5,
    parameter logic [CFG_W-1:0]   CFG_INIT      = {CFG_W{1'b0}},
    parameter int                 STABLE_CYCLES = 16,
    parameter int                 FLUSH_CYCLES  = 4,
    parameter int                 DRAIN_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CFG_W-1:0]  cfg_raw,
    input  logic              start_in,
    output logic              start_ack_out,
    output logic              start_out,
    input  logic              start_ack_in,
    input  logic              pipe_idle,
    output logic [CFG_W-1:0]  cfg,
    output logic              flush,
    output logic [7:0]        change_count,
    output logic              drain_timeout
);

    // Counter widths; each counter only has to reach its "last" value.
    localparam int ST_W  = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int FL_W  = (FLUSH_CYCLES  > 1) ? $clog2(FLUSH_CYCLES)  : 1;
    localparam int TMO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    localparam logic [ST_W-1:0]  STABLE_LAST = ST_W'(STABLE_CYCLES - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST  = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_PASS  = 2'd3
    } state_t;

    // Debounce path
    logic [CFG_W-1:0] sync1_r;
    logic [CFG_W-1:0] sync2_r;        // cfg_sync
    logic [ST_W-1:0]  stab_cnt_r;
    logic [CFG_W-1:0] stable_cfg_r;

    // Sequencer state
    state_t           state_r;
    logic [CFG_W-1:0] target_cfg_r;   // stable_cfg captured at the IDLE decision
    logic [CFG_W-1:0] cfg_r;
    logic             flush_r;
    logic [7:0]       change_count_r;
    logic             drain_timeout_r;
    logic [FL_W-1:0]  flush_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_r;

    logic             pass_s;

    // Synchronize the switches and accept a value only after it has held still.
    // sync1 != sync2 means cfg_sync is changing on this edge, so the run
    // counter restarts together with the new cfg_sync value; this gives the
    // 2 + STABLE_CYCLES latency from a switch change to stable_cfg.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r      <= CFG_INIT;
            sync2_r      <= CFG_INIT;
            stab_cnt_r   <= {ST_W{1'b0}};
            stable_cfg_r <= CFG_INIT;
        end else begin
            sync1_r <= cfg_raw;
            sync2_r <= sync1_r;
            if (sync1_r != sync2_r) begin
                stab_cnt_r <= {ST_W{1'b0}};
            end else if (stab_cnt_r != STABLE_LAST) begin
                stab_cnt_r <= stab_cnt_r + ST_W'(1);
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
            if (stab_cnt_r == STABLE_LAST) begin
                stable_cfg_r <= sync2_r;
            end else begin
                stable_cfg_r <= stable_cfg_r;
            end
        end
    end

    // Frame sequencer: decide at start, drain, flush, then pass the handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            target_cfg_r    <= CFG_INIT;
            cfg_r           <= CFG_INIT;
            flush_r         <= 1'b0;
            change_count_r  <= 8'd0;
            drain_timeout_r <= 1'b0;
            flush_cnt_r     <= {FL_W{1'b0}};
            tmo_cnt_r       <= {TMO_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    flush_r <= 1'b0;
                    if (start_in) begin
                        if (stable_cfg_r != cfg_r) begin
                            // Later switch movement is ignored until the next decision.
                            target_cfg_r <= stable_cfg_r;
                            tmo_cnt_r    <= {TMO_W{1'b0}};
                            state_r      <= ST_DRAIN;
                        end else begin
                            state_r <= ST_PASS;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_idle || (tmo_cnt_r == TMO_LAST)) begin
                        if (!pipe_idle) begin
                            drain_timeout_r <= 1'b1;
                        end else begin
                            drain_timeout_r <= drain_timeout_r;
                        end
                        // cfg and flush change together on FLUSH entry.
                        cfg_r          <= target_cfg_r;
                        change_count_r <= change_count_r + 8'd1;
                        flush_cnt_r    <= {FL_W{1'b0}};
                        flush_r        <= 1'b1;
                        state_r        <= ST_FLUSH;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                        state_r   <= ST_DRAIN;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r == FLUSH_LAST) begin
                        // flush drops on the edge PASS is entered.
                        flush_r <= 1'b0;
                        state_r <= ST_PASS;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + FL_W'(1);
                        flush_r     <= 1'b1;
                        state_r     <= ST_FLUSH;
                    end
                end
                ST_PASS: begin
                    flush_r <= 1'b0;
                    if (!start_in) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_PASS;
                    end
                end
                default: begin
                    flush_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // The handshake passes through combinationally, gated by the registered state.
    assign pass_s        = (state_r == ST_PASS);
    assign start_out     = pass_s & start_in;
    assign start_ack_out = pass_s & start_ack_in;

    assign cfg           = cfg_r;
    assign flush         = flush_r;
    assign change_count  = change_count_r;
    assign drain_timeout = drain_timeout_r;

endmodule
